// File: rtl/sdram_arb_pkg.sv
// Shared types for the N-port SDRAM arbiter: FSM state, latched command
// record and an index-width helper.
package sdram_arb_pkg;

  localparam int CMD_ADDR_W = 24;
  localparam int CMD_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef struct packed {
    logic                  wr;
    logic                  burst;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [1:0]            wmask;
  } sdram_cmd_t;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_rr_arbiter.sv
// Combinational winner selection: fixed priority over the low ports, then
// round-robin over the rest starting at the rotating pointer.
module prio_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 3,
  parameter  int PRIO_PORTS = 1,
  localparam int IW         = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_pending,
  input  logic [IW-1:0]        i_rr_ptr,
  output logic                 o_valid,
  output logic [NUM_PORTS-1:0] o_grant_oh,
  output logic [IW-1:0]        o_grant_idx,
  output logic [IW-1:0]        o_next_ptr
);

  localparam int RR_N = NUM_PORTS - PRIO_PORTS;

  always_comb begin
    int          w_p;
    logic [IW-1:0] w_idx;
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves a value held, which would otherwise infer a latch.
    o_valid     = 1'b0;
    o_grant_idx = '0;
    o_next_ptr  = i_rr_ptr;
    w_p         = 0;
    w_idx       = '0;

    for (int i = 0; i < PRIO_PORTS; i++) begin
      if (!o_valid && i_pending[i]) begin
        o_valid     = 1'b1;
        o_grant_idx = IW'(i);
      end
    end

    // Walk the round-robin ring once, wrapping back to the first RR port.
    for (int k = 0; k < RR_N; k++) begin
      w_p = int'(i_rr_ptr) + k;
      if (w_p >= NUM_PORTS) w_p = w_p - RR_N;
      w_idx = IW'(w_p);
      if (!o_valid && i_pending[w_idx]) begin
        o_valid     = 1'b1;
        o_grant_idx = w_idx;
        o_next_ptr  = (w_p + 1 >= NUM_PORTS) ? IW'(PRIO_PORTS) : IW'(w_p + 1);
      end
    end
  end

  assign o_grant_oh = o_valid ? (NUM_PORTS'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-port front end for the single SDRAM controller port: per-port one-entry
// command latches, priority/round-robin grant and per-owner ack routing.
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 3,
  parameter  int PRIO_PORTS = 1,
  parameter  int ADDR_W     = 24,
  parameter  int DATA_W     = 16,
  parameter  int BURST_LEN  = 4,
  localparam int IW         = idx_w(NUM_PORTS)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        port_rd_i,
  input  logic [NUM_PORTS-1:0]        port_wr_i,
  input  logic [NUM_PORTS-1:0]        port_burst_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata_i,
  input  logic [NUM_PORTS*2-1:0]      port_wmask_i,
  output logic [NUM_PORTS-1:0]        port_rdy_o,
  output logic [NUM_PORTS-1:0]        port_ack_o,
  output logic [DATA_W-1:0]           port_rdata_o,
  output logic [NUM_PORTS-1:0]        port_ovf_o,
  output logic                        sdram_rd,
  output logic                        sdram_wr,
  output logic [ADDR_W-1:0]           sdram_addr_x16,
  output logic [DATA_W-1:0]           sdram_wdata,
  output logic [1:0]                  sdram_wmask,
  output logic                        sdram_burst,
  input  logic [DATA_W-1:0]           sdram_rdata,
  input  logic                        sdram_ack,
  input  logic                        sdram_rdy,
  output logic [IW-1:0]               grant_o,
  output logic                        busy_o
);

  localparam int CW = idx_w(BURST_LEN + 1);

  arb_state_e           r_state;
  logic [NUM_PORTS-1:0] r_valid;
  sdram_cmd_t           r_lat [NUM_PORTS];
  sdram_cmd_t           r_out;
  logic                 r_sdram_rd;
  logic                 r_sdram_wr;
  logic [IW-1:0]        r_owner;
  logic [NUM_PORTS-1:0] r_owner_oh;
  logic [IW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_cnt;

  logic                 w_valid;
  logic [NUM_PORTS-1:0] w_grant_oh;
  logic [IW-1:0]        w_grant_idx;
  logic [IW-1:0]        w_next_ptr;
  logic [NUM_PORTS-1:0] w_strobe;
  logic                 w_ack_wait;
  logic                 w_final;

  prio_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PRIO_PORTS(PRIO_PORTS)
  ) u_arb (
    .i_pending  (r_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_valid    (w_valid),
    .o_grant_oh (w_grant_oh),
    .o_grant_idx(w_grant_idx),
    .o_next_ptr (w_next_ptr)
  );

  assign w_strobe = port_rd_i | port_wr_i;
  // Acks are gated by reset so an abort silences the ports in the same cycle.
  assign w_ack_wait = (r_state == WAIT) && sdram_ack && !rst_i;
  assign w_final    = w_ack_wait && (r_cnt == CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_final && r_owner_oh[i]) r_valid[i] <= 1'b0;
        else if (!r_valid[i] && w_strobe[i]) r_valid[i] <= 1'b1;
      end
    end
  end

  // NOTE: only the valid bits are reset; the latched payload is don't-care
  // while its valid bit is clear, so it needs no reset path.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!r_valid[i] && w_strobe[i]) begin
        r_lat[i].wr    <= port_wr_i[i];
        r_lat[i].burst <= port_burst_i[i] & ~port_wr_i[i];
        r_lat[i].addr  <= CMD_ADDR_W'(port_addr_i[i*ADDR_W +: ADDR_W]);
        r_lat[i].wdata <= CMD_DATA_W'(port_wdata_i[i*DATA_W +: DATA_W]);
        r_lat[i].wmask <= port_wmask_i[i*2 +: 2];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every branch sees
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_sdram_rd <= 1'b0;
      r_sdram_wr <= 1'b0;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_rr_ptr   <= IW'(PRIO_PORTS);
      r_cnt      <= '0;
      r_out      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && sdram_rdy) begin
            r_out      <= r_lat[w_grant_idx];
            r_owner    <= w_grant_idx;
            r_owner_oh <= w_grant_oh;
            r_sdram_rd <= ~r_lat[w_grant_idx].wr;
            r_sdram_wr <= r_lat[w_grant_idx].wr;
            if (int'(w_grant_idx) >= PRIO_PORTS) r_rr_ptr <= w_next_ptr;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_sdram_rd <= 1'b0;
          r_sdram_wr <= 1'b0;
          r_cnt      <= r_out.burst ? CW'(BURST_LEN) : CW'(1);
          r_state    <= WAIT;
        end
        WAIT: begin
          if (w_ack_wait) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign port_rdy_o     = ~r_valid;
  assign port_ack_o     = w_ack_wait ? r_owner_oh : '0;
  assign port_rdata_o   = sdram_rdata;
  assign port_ovf_o     = w_strobe & r_valid & {NUM_PORTS{!rst_i}};
  assign sdram_rd       = r_sdram_rd;
  assign sdram_wr       = r_sdram_wr;
  assign sdram_addr_x16 = ADDR_W'(r_out.addr);
  assign sdram_wdata    = DATA_W'(r_out.wdata);
  assign sdram_wmask    = r_out.wmask;
  assign sdram_burst    = r_out.burst;
  assign grant_o        = r_owner;
  assign busy_o         = (r_state != IDLE);

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench for sdram_arbiter_n: single/burst reads, round-robin
// alternation, priority preemption, overflow and mid-burst reset.
module tb_sdram_arbiter_n;

  localparam int N  = 3;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    port_rd_i = '0;
  logic [N-1:0]    port_wr_i = '0;
  logic [N-1:0]    port_burst_i = '0;
  logic [N*AW-1:0] port_addr_i = '0;
  logic [N*DW-1:0] port_wdata_i = '0;
  logic [N*2-1:0]  port_wmask_i = '0;
  logic [N-1:0]    port_rdy_o, port_ack_o, port_ovf_o;
  logic [DW-1:0]   port_rdata_o;
  logic            sdram_rd, sdram_wr, sdram_burst;
  logic [AW-1:0]   sdram_addr_x16;
  logic [DW-1:0]   sdram_wdata;
  logic [1:0]      sdram_wmask;
  logic [DW-1:0]   sdram_rdata = '0;
  logic            sdram_ack = 1'b0;
  logic            sdram_rdy = 1'b1;
  logic [1:0]      grant_o;
  logic            busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  sdram_arbiter_n #(
    .NUM_PORTS(N), .PRIO_PORTS(1), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .port_rd_i(port_rd_i), .port_wr_i(port_wr_i), .port_burst_i(port_burst_i),
    .port_addr_i(port_addr_i), .port_wdata_i(port_wdata_i), .port_wmask_i(port_wmask_i),
    .port_rdy_o(port_rdy_o), .port_ack_o(port_ack_o), .port_rdata_o(port_rdata_o),
    .port_ovf_o(port_ovf_o),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr_x16(sdram_addr_x16),
    .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask), .sdram_burst(sdram_burst),
    .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] m);
    port_addr_i[p*AW +: AW]  = a;
    port_wdata_i[p*DW +: DW] = d;
    port_wmask_i[p*2 +: 2]   = m;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    port_rd_i = '0; port_wr_i = '0; port_burst_i = '0; sdram_ack = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  // Returns in the cycle a command strobe is visible, bounded.
  task automatic wait_issue();
    bit seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      if (sdram_rd || sdram_wr) seen = 1'b1;
      else tick();
    end
    check("issue_seen", 32'(seen), 32'd1);
  endtask

  task automatic single_ack(input logic [DW-1:0] d, input logic [N-1:0] exp_ack);
    sdram_ack = 1'b1; sdram_rdata = d;
    #1 check("ack_route", 32'(port_ack_o), 32'(exp_ack));
    tick();
    sdram_ack = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_rdy", 32'(port_rdy_o), 32'b111);
    check("rst_ack", 32'(port_ack_o), 32'b000);
    check("rst_ovf", 32'(port_ovf_o), 32'b000);
    check("rst_cmd", 32'({sdram_rd, sdram_wr}), 32'b00);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);

    // Single read on port 1, ack 3 cycles after sdram_rd.
    set_port(1, 24'h000100, 16'h0, 2'b11);
    port_rd_i[1] = 1'b1; tick(); port_rd_i = '0;
    check("t1_rdy_low", 32'(port_rdy_o), 32'b101);
    check("t1_busy_t1", 32'(busy_o), 32'd0);
    tick();
    check("t1_rd_t2", 32'(sdram_rd), 32'd1);
    check("t1_addr", 32'(sdram_addr_x16), 32'h000100);
    check("t1_grant", 32'(grant_o), 32'd1);
    check("t1_burst", 32'(sdram_burst), 32'd0);
    tick();
    check("t1_rd_one_cycle", 32'(sdram_rd), 32'd0);
    tick(); tick();
    sdram_ack = 1'b1; sdram_rdata = 16'hBEEF;
    #1;
    check("t1_ack", 32'(port_ack_o), 32'b010);
    check("t1_rdata", 32'(port_rdata_o), 32'hBEEF);
    check("t1_rdy_still_low", 32'(port_rdy_o[1]), 32'd0);
    tick(); sdram_ack = 1'b0;
    check("t1_rdy_back", 32'(port_rdy_o), 32'b111);
    check("t1_idle", 32'(busy_o), 32'd0);

    // Burst read on port 0: four acks carrying 1..4.
    set_port(0, 24'h000200, 16'h0, 2'b11);
    port_rd_i[0] = 1'b1; port_burst_i[0] = 1'b1; tick();
    port_rd_i = '0; port_burst_i = '0;
    tick();
    check("t2_rd", 32'(sdram_rd), 32'd1);
    check("t2_burst", 32'(sdram_burst), 32'd1);
    check("t2_grant", 32'(grant_o), 32'd0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      sdram_ack = 1'b1; sdram_rdata = DW'(k);
      #1;
      check("t2_ack", 32'(port_ack_o), 32'b001);
      check("t2_data", 32'(port_rdata_o), 32'(k));
      check("t2_pending", 32'(port_rdy_o[0]), 32'd0);
      tick();
    end
    sdram_ack = 1'b0;
    check("t2_cleared", 32'(port_rdy_o), 32'b111);

    // Ports 1 and 2 write continuously: grants alternate 1,2,1,2.
    do_reset();
    set_port(1, 24'h001111, 16'h1111, 2'b11);
    set_port(2, 24'h002222, 16'h2222, 2'b11);
    port_burst_i = 3'b110;
    port_wr_i = 3'b110; tick(); port_wr_i = '0;
    for (int g = 0; g < 4; g++) begin
      int exp_p;
      exp_p = (g % 2 == 0) ? 1 : 2;
      wait_issue();
      check("t3_grant", 32'(grant_o), 32'(exp_p));
      check("t3_wr", 32'(sdram_wr), 32'd1);
      check("t3_wdata", 32'(sdram_wdata), (exp_p == 1) ? 32'h1111 : 32'h2222);
      check("t3_burst_forced0", 32'(sdram_burst), 32'd0);
      tick();
      single_ack(16'h0, N'(1) << exp_p);
      port_wr_i[exp_p] = 1'b1; tick(); port_wr_i = '0;
    end
    port_burst_i = '0;

    // Port 0 arrives during a port-2 write and beats pending port 1.
    do_reset();
    set_port(2, 24'h000302, 16'h2020, 2'b11);
    port_wr_i[2] = 1'b1; tick(); port_wr_i = '0;
    wait_issue();
    check("t4_first", 32'(grant_o), 32'd2);
    tick();
    set_port(1, 24'h000301, 16'h1010, 2'b11);
    set_port(0, 24'h000300, 16'h0, 2'b11);
    port_wr_i[1] = 1'b1; port_rd_i[0] = 1'b1; tick();
    port_wr_i = '0; port_rd_i = '0;
    single_ack(16'h0, 3'b100);
    wait_issue();
    check("t4_prio", 32'(grant_o), 32'd0);
    check("t4_prio_rd", 32'(sdram_rd), 32'd1);
    tick();
    single_ack(16'h0, 3'b001);
    wait_issue();
    check("t4_then_rr", 32'(grant_o), 32'd1);
    tick();
    single_ack(16'h0, 3'b010);

    // Overflow on port 2 while busy; also strobe in the final-ack cycle.
    do_reset();
    set_port(2, 24'h000300, 16'hAAAA, 2'b10);
    port_wr_i[2] = 1'b1; tick(); port_wr_i = '0;
    wait_issue();
    check("t5_wdata", 32'(sdram_wdata), 32'hAAAA);
    check("t5_wmask", 32'(sdram_wmask), 32'b10);
    tick();
    set_port(2, 24'h000999, 16'h5555, 2'b01);
    port_wr_i[2] = 1'b1;
    #1 check("t5_ovf", 32'(port_ovf_o), 32'b100);
    tick(); port_wr_i = '0;
    #1 check("t5_ovf_pulse", 32'(port_ovf_o), 32'b000);
    check("t5_addr_held", 32'(sdram_addr_x16), 32'h000300);
    check("t5_wdata_held", 32'(sdram_wdata), 32'hAAAA);
    sdram_ack = 1'b1; port_wr_i[2] = 1'b1;
    #1;
    check("t5_final_ack", 32'(port_ack_o), 32'b100);
    check("t5_final_ovf", 32'(port_ovf_o), 32'b100);
    tick(); sdram_ack = 1'b0; port_wr_i = '0;
    check("t5_rdy_back", 32'(port_rdy_o), 32'b111);
    tick();
    check("t5_no_reissue", 32'({sdram_rd, sdram_wr}), 32'b00);
    check("t5_idle", 32'(busy_o), 32'd0);

    // Reset during a burst WAIT, with the controller still acking.
    do_reset();
    set_port(1, 24'h000400, 16'h0, 2'b11);
    port_rd_i[1] = 1'b1; port_burst_i[1] = 1'b1; tick();
    port_rd_i = '0; port_burst_i = '0;
    wait_issue();
    check("t6_burst", 32'(sdram_burst), 32'd1);
    tick();
    single_ack(16'h0007, 3'b010);
    rst_i = 1'b1; sdram_ack = 1'b1;
    #1 check("t6_ack_in_reset", 32'(port_ack_o), 32'b000);
    tick(); rst_i = 1'b0;
    #1;
    check("t6_late_ack", 32'(port_ack_o), 32'b000);
    check("t6_rdy", 32'(port_rdy_o), 32'b111);
    check("t6_idle", 32'(busy_o), 32'd0);
    tick(); sdram_ack = 1'b0;
    set_port(2, 24'h000500, 16'h0, 2'b11);
    port_rd_i[2] = 1'b1; tick(); port_rd_i = '0;
    wait_issue();
    check("t6_next_grant", 32'(grant_o), 32'd2);
    check("t6_next_addr", 32'(sdram_addr_x16), 32'h000500);
    check("t6_next_rd", 32'(sdram_rd), 32'd1);
    tick();
    sdram_ack = 1'b1; sdram_rdata = 16'h1234;
    #1;
    check("t6_next_ack", 32'(port_ack_o), 32'b100);
    check("t6_next_data", 32'(port_rdata_o), 32'h1234);
    tick(); sdram_ack = 1'b0;
    check("t6_done", 32'(port_rdy_o), 32'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_n.md
# sdram_arbiter_n

N-port successor to the two-client SDRAM arbiter: it multiplexes any number of masters (video scan-out, CPU memory controller, future blitter/DMA) onto the single `sdram_pnru` system-side port. Each port has its own one-entry command latch. Arbitration is fixed priority for the lowest-indexed ports (real-time video) and round-robin for the rest. Burst reads of `BURST_LEN` words are routed to the owning port.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of client ports, ≥2.
- `PRIO_PORTS`, 1: ports `0..PRIO_PORTS-1` use fixed priority, lowest index wins; the remaining ports are round-robin.
- `ADDR_W`, 24: SDRAM word (x16) address width.
- `DATA_W`, 16: data width.
- `BURST_LEN`, 4: words returned per burst read.

Ports (the clock is single; the reset is synchronous and active-high):
- `clk_i` in 1: system clock.
- `rst_i` in 1: synchronous, active-high reset.
- `port_rd_i` in N: read strobe per port.
- `port_wr_i` in N: write strobe per port.
- `port_burst_i` in N: burst read request. Ignored on writes.
- `port_addr_i` in N*ADDR_W: address per port, packed, port 0 in the LSBs.
- `port_wdata_i` in N*DATA_W: write data per port.
- `port_wmask_i` in N*2: byte mask per port.
- `port_rdy_o` out N: port latch empty; a strobe is accepted.
- `port_ack_o` out N: per-word read data valid, or write done.
- `port_rdata_o` out DATA_W: shared read data, broadcast to all ports; qualify with `port_ack_o`.
- `port_ovf_o` out N: 1-cycle pulse when a strobe arrives while `port_rdy_o`=0.
- `sdram_rd`, `sdram_wr` out 1: command strobes to the controller.
- `sdram_addr_x16` out ADDR_W; `sdram_wdata` out DATA_W; `sdram_wmask` out 2; `sdram_burst` out 1.
- `sdram_rdata` in DATA_W; `sdram_ack` in 1; `sdram_rdy` in 1.
- `grant_o` out $clog2(N): index of the current or last owner, for debug.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- Port latch:
  - When `port_rdy_o[i]`=1, a cycle with `rd` or `wr` captures {op, addr, wdata, wmask, burst}.
  - `burst` is forced to 0 when op=wr.
  - `rd` and `wr` together: `wr` wins.
  - A strobe when not ready is dropped and `port_ovf_o[i]` pulses.
- FSM states:
  - IDLE: if any latch is pending and `sdram_rdy`=1, select a winner, register the command outputs, then go to ISSUE.
  - ISSUE: `sdram_rd`/`sdram_wr` is high for exactly this one cycle; load the ack counter with BURST_LEN if burst, else 1; go to WAIT.
  - WAIT: each `sdram_ack` pulses `port_ack_o[owner]` and decrements the counter. On the final ack, clear the owner latch and go to IDLE.
- Winner selection:
  - Any pending priority port wins, lowest index first.
  - Otherwise the first pending round-robin port at or after `rr_ptr`.
  - `rr_ptr` advances to winner+1, wrapping to `PRIO_PORTS`, only on round-robin grants.
- `sdram_ack` received in IDLE or ISSUE is ignored.
- `sdram_addr_x16`, `sdram_wdata`, `sdram_wmask`, `sdram_burst` hold their values from ISSUE until the next grant.

## Timing
- Reset values:
  - All `port_rdy_o`=1; `port_ack_o`, `port_ovf_o`, `sdram_rd`, `sdram_wr`, `busy_o`=0.
  - `grant_o`=0; `rr_ptr`=`PRIO_PORTS`; all latches empty; FSM in IDLE.
- Reset mid-transaction aborts immediately. Late controller acks after reset are dropped.
- Strobe at cycle T:
  - `port_rdy_o`=0 at T+1.
  - If IDLE and `sdram_rdy`=1 at T+1, the grant is registered at T+1 and `sdram_rd`/`sdram_wr`=1 at T+2.
- `port_ack_o` and `port_rdata_o` are combinational from `sdram_ack` and `sdram_rdata`: zero added latency.
- `port_rdy_o[owner]` returns to 1 the cycle after the final ack. The port may re-strobe in that cycle.
- Back-to-back grants: the next winner is evaluated in the IDLE cycle following the final ack, so there is a minimum of 1 idle cycle between commands.
- Simultaneous strobe on a port and final ack for the same port: the strobe is dropped with `ovf`, because `rdy` is still 0.

## Structure
- Package `sdram_arb_pkg` holds:
  - the state enum {IDLE, ISSUE, WAIT};
  - the packed struct `sdram_cmd_t` {wr, burst, addr, wdata, wmask};
  - a `$clog2` width helper.
- Sub-module `prio_rr_arbiter`: pending mask + `rr_ptr` in, one-hot grant + index + next pointer out. Purely combinational selection, parametrised by `NUM_PORTS` and `PRIO_PORTS`.

## Test plan
- Single read, port 1, addr 24'h000100, controller acks 3 cycles after `sdram_rd` with 16'hBEEF:
  - `sdram_rd` at T+2;
  - `port_ack_o`=3'b010 with 16'hBEEF;
  - `port_rdy_o[1]` high one cycle later.
- Burst read, port 0, BURST_LEN=4, acks carry 1,2,3,4 → four `port_ack_o[0]` pulses with data 1..4, then the latch clears.
- Ports 1 and 2 write continuously, N=3 → grants alternate 1,2,1,2.
- Port 0 strobes while a port-2 write is in WAIT → port 0 is granted next, ahead of pending port 1.
- Strobe on port 2 while `port_rdy_o[2]`=0 → `port_ovf_o`=3'b100 for one cycle; the original command completes unchanged.
- `rst_i` asserted during WAIT of a burst, with controller acks continuing 2 cycles → no `port_ack_o`; all `rdy`=1 after reset; the next read issues normally.
